// File: rtl/key_cond_pkg.sv
// key_cond_pkg: shared FSM state type and counter sizing helper for the key conditioner.
package key_cond_pkg;

    typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} key_state_t;

    function automatic int cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/key_channel.sv
// key_channel: synchronise, debounce and classify one active-low key, with optional auto-repeat.
module key_channel
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_EN       = 0,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Key_n,
    output logic Level,
    output logic Pressed,
    output logic Released,
    output logic Repeat
);

    localparam int DW   = cnt_width(DEBOUNCE_CYCLES);
    localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RW   = cnt_width(RMAX);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          sync;
    key_state_t    state;
    logic [DW-1:0] cnt;
    logic [RW-1:0] rtimer;
    logic          rep_phase;
    logic          rep_hit;

    assign sync    = sync_q[1];
    // rep_phase selects the initial hold delay versus the steady repeat period
    assign rep_hit = rtimer == (rep_phase ? REP_LAST : HOLD_LAST);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            sync_q    <= '0;
            state     <= IDLE;
            cnt       <= '0;
            rtimer    <= '0;
            rep_phase <= 1'b0;
            Level     <= 1'b0;
            Pressed   <= 1'b0;
            Released  <= 1'b0;
            Repeat    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], ~Key_n};
            Pressed  <= 1'b0;
            Released <= 1'b0;
            Repeat   <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync) begin
                        state <= DB_PRESS;
                        cnt   <= '0;
                    end
                end
                DB_PRESS: begin
                    if (!sync) begin
                        state <= IDLE;
                    end else if (cnt == DB_LAST) begin
                        state     <= HELD;
                        Pressed   <= 1'b1;
                        Level     <= 1'b1;
                        rtimer    <= '0;
                        rep_phase <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!sync) begin
                        state <= DB_RELEASE;
                        cnt   <= '0;
                    end else if (REPEAT_EN != 0) begin
                        if (rep_hit) begin
                            Repeat    <= 1'b1;
                            rtimer    <= '0;
                            rep_phase <= 1'b1;
                        end else begin
                            rtimer <= rtimer + 1'b1;
                        end
                    end
                end
                DB_RELEASE: begin
                    if (sync) begin
                        state     <= HELD;
                        rtimer    <= '0;
                        rep_phase <= 1'b0;
                    end else if (cnt == DB_LAST) begin
                        state    <= IDLE;
                        Released <= 1'b1;
                        Level    <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: N independent debounced key channels with press, release and repeat strobes.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_EN       = 0,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [N_KEYS-1:0] Keys_n,
    output logic [N_KEYS-1:0] Level,
    output logic [N_KEYS-1:0] Pressed,
    output logic [N_KEYS-1:0] Released,
    output logic [N_KEYS-1:0] Repeat
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_EN      (REPEAT_EN),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_ch (
            .Clk     (Clk),
            .Reset   (Reset),
            .Key_n   (Keys_n[i]),
            .Level   (Level[i]),
            .Pressed (Pressed[i]),
            .Released(Released[i]),
            .Repeat  (Repeat[i])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed and random key stimulus checked against a run-length reference model.
module tb_key_conditioner;

    localparam int N    = 4;
    localparam int D    = 4;
    localparam int HOLD = 10;
    localparam int RPT  = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] keys_n = '1;
    logic [N-1:0] level, pressed, released, rep;
    logic [N-1:0] level0, pressed0, released0, rep0;

    int checks = 0;
    int errors = 0;
    int cnt_p[N], cnt_r[N], cnt_rep[N];
    int cnt_rep0 = 0;

    key_conditioner #(
        .N_KEYS(N), .DEBOUNCE_CYCLES(D), .REPEAT_EN(1), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(RPT)
    ) dut (
        .Clk(clk), .Reset(reset), .Keys_n(keys_n),
        .Level(level), .Pressed(pressed), .Released(released), .Repeat(rep)
    );

    key_conditioner #(
        .N_KEYS(N), .DEBOUNCE_CYCLES(D), .REPEAT_EN(0), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(RPT)
    ) dut0 (
        .Clk(clk), .Reset(reset), .Keys_n(keys_n),
        .Level(level0), .Pressed(pressed0), .Released(released0), .Repeat(rep0)
    );

    always #5 clk = ~clk;

    // Reference: a change is accepted once D+1 consecutive seen samples differ from the level;
    // repeats fire at HOLD, HOLD+RPT, ... uninterrupted held cycles after entering the held state.
    logic [N-1:0] s1 = '0, s2 = '0;
    logic [N-1:0] e_lvl = '0, e_prs = '0, e_rel = '0, e_rep = '0;
    int run[N], t[N];

    always @(posedge clk) begin
        if (!reset) begin
            s1 = '0; s2 = '0;
            e_lvl = '0; e_prs = '0; e_rel = '0; e_rep = '0;
            for (int i = 0; i < N; i++) begin
                run[i] = 0;
                t[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                e_prs[i] = 1'b0;
                e_rel[i] = 1'b0;
                e_rep[i] = 1'b0;
                if (s2[i] != e_lvl[i]) begin
                    run[i]++;
                    if (run[i] == D + 1) begin
                        e_lvl[i] = s2[i];
                        run[i] = 0;
                        t[i] = 0;
                        if (s2[i]) e_prs[i] = 1'b1;
                        else e_rel[i] = 1'b1;
                    end
                end else begin
                    if (e_lvl[i] && run[i] == 0) begin
                        t[i]++;
                        if (t[i] >= HOLD && (t[i] - HOLD) % RPT == 0) e_rep[i] = 1'b1;
                    end else begin
                        t[i] = 0;
                    end
                    run[i] = 0;
                end
            end
            s2 = s1;
            s1 = ~keys_n;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            cnt_p[i]   += int'(pressed[i]);
            cnt_r[i]   += int'(released[i]);
            cnt_rep[i] += int'(rep[i]);
            cnt_rep0   += int'(rep0[i]);
        end
        chk("m_level", 32'(level), 32'(e_lvl));
        chk("m_pressed", 32'(pressed), 32'(e_prs));
        chk("m_released", 32'(released), 32'(e_rel));
        chk("m_repeat", 32'(rep), 32'(e_rep));
        chk("m_level0", 32'(level0), 32'(e_lvl));
        chk("m_pressed0", 32'(pressed0), 32'(e_prs));
        chk("m_released0", 32'(released0), 32'(e_rel));
        chk("m_repeat0", 32'(rep0), 32'(0));
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            cnt_p[i] = 0; cnt_r[i] = 0; cnt_rep[i] = 0;
        end
        @(negedge clk);
        tick(); tick();
        chk("rst_level", 32'(level), 32'(0));
        chk("rst_pressed", 32'(pressed), 32'(0));
        chk("rst_released", 32'(released), 32'(0));
        chk("rst_repeat", 32'(rep), 32'(0));
        reset = 1'b1;
        repeat (3) tick();

        keys_n[0] = 1'b0;
        repeat (6) tick();
        chk("press_early", 32'(pressed[0]), 32'(0));
        tick();
        chk("press_edge6", 32'(pressed[0]), 32'(1));
        chk("press_level", 32'(level[0]), 32'(1));
        tick();
        chk("press_once", 32'(pressed[0]), 32'(0));
        chk("press_level_hold", 32'(level[0]), 32'(1));
        repeat (5) tick();
        keys_n[0] = 1'b1;
        repeat (6) tick();
        chk("release_early", 32'(released[0]), 32'(0));
        tick();
        chk("release_edge6", 32'(released[0]), 32'(1));
        chk("release_level", 32'(level[0]), 32'(0));
        tick();
        chk("release_once", 32'(released[0]), 32'(0));

        repeat (5) begin
            keys_n[1] = 1'b0;
            repeat (3) tick();
            keys_n[1] = 1'b1;
            repeat (3) tick();
        end
        repeat (8) tick();
        chk("bounce_level", 32'(level[1]), 32'(0));
        chk("bounce_press_cnt", 32'(cnt_p[1]), 32'(0));
        chk("bounce_rel_cnt", 32'(cnt_r[1]), 32'(0));

        keys_n[2] = 1'b0;
        repeat (10) tick();
        keys_n[2] = 1'b1;
        repeat (2) tick();
        keys_n[2] = 1'b0;
        repeat (12) tick();
        chk("relbounce_level", 32'(level[2]), 32'(1));
        chk("relbounce_press_cnt", 32'(cnt_p[2]), 32'(1));
        chk("relbounce_rel_cnt", 32'(cnt_r[2]), 32'(0));
        keys_n[2] = 1'b1;
        repeat (10) tick();

        keys_n[3] = 1'b0;
        repeat (7) tick();
        chk("rep_pressed", 32'(pressed[3]), 32'(1));
        repeat (9) tick();
        chk("rep_early", 32'(rep[3]), 32'(0));
        tick();
        chk("rep_first", 32'(rep[3]), 32'(1));
        repeat (20) tick();
        chk("rep_count", 32'(cnt_rep[3]), 32'(7));
        chk("rep_disabled_count", 32'(cnt_rep0), 32'(0));
        keys_n[3] = 1'b1;
        repeat (10) tick();

        keys_n = '0;
        repeat (6) tick();
        chk("simul_early", 32'(pressed), 32'(0));
        tick();
        chk("simul_pressed", 32'(pressed), 32'hF);
        repeat (3) tick();

        reset = 1'b0;
        tick();
        chk("midrst_level", 32'(level), 32'(0));
        chk("midrst_released", 32'(released), 32'(0));
        chk("midrst_pressed", 32'(pressed), 32'(0));
        chk("midrst_repeat", 32'(rep), 32'(0));
        tick();
        reset = 1'b1;
        repeat (6) tick();
        chk("rerst_early", 32'(pressed[0]), 32'(0));
        tick();
        chk("rerst_pressed", 32'(pressed), 32'hF);

        keys_n = '1;
        repeat (10) tick();
        for (int n = 0; n < 80; n++) begin
            keys_n = 4'($urandom);
            repeat ($urandom_range(1, 12)) tick();
            if ($urandom_range(0, 15) == 0) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end
        end
        keys_n = '1;
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Parametrised front end for the board's active-low pushbuttons (Run, Continue, and similar user keys). For each of `N_KEYS` raw inputs it synchronises, debounces and classifies the input. It produces a debounced level, one-cycle press and release strobes, and optional auto-repeat strobes for the top-level control FSM. It replaces the single ad-hoc Run pulse with a uniform, N-channel block. The system reset pin never passes through this block.

## Interface
- `N_KEYS`, 4: number of independent key channels (1–16).
- `DEBOUNCE_CYCLES`, 500000: consecutive stable synchronised samples required to accept a change. This is 10 ms at 50 MHz. Must be ≥1.
- `REPEAT_EN`, 0: 1 enables auto-repeat strobes. 0 ties `Repeat` to 0.
- `HOLD_CYCLES`, 25000000: cycles in HELD before the first repeat strobe.
- `REPEAT_CYCLES`, 5000000: cycles between subsequent repeat strobes.

- `Clk` input 1: system clock, 50 MHz.
- `Reset` input 1: synchronous, active-low reset.
- `Keys_n` input N_KEYS: raw asynchronous buttons. 0 = pressed.
- `Level` output N_KEYS: debounced state. 1 = pressed.
- `Pressed` output N_KEYS: one-cycle strobe when a press is accepted.
- `Released` output N_KEYS: one-cycle strobe when a release is accepted.
- `Repeat` output N_KEYS: one-cycle auto-repeat strobe while held.

## Operation
- Per channel: a 2-flop synchroniser on `~Keys_n[i]` gives `sync`. The synchroniser resets to 0.
- FSM states are IDLE, DB_PRESS, HELD and DB_RELEASE.
  - **IDLE:** on `sync`=1, go to DB_PRESS with `cnt`=0.
  - **DB_PRESS:** on `sync`=0, return to IDLE with no strobe (bounce). On `sync`=1 and `cnt`==D-1, go to HELD and assert `Pressed`. Otherwise increment `cnt`.
  - **HELD:** on `sync`=0, go to DB_RELEASE with `cnt`=0. Otherwise advance the repeat timer.
  - **DB_RELEASE:** on `sync`=1, return to HELD with no strobe. The repeat timer restarts at 0. On `sync`=0 and `cnt`==D-1, go to IDLE and assert `Released`. Otherwise increment `cnt`.
- `Level`=1 in HELD and DB_RELEASE, and 0 otherwise.
- Repeat timer (only when `REPEAT_EN`=1):
  - Clears on entry to HELD.
  - Issues a `Repeat` strobe when it reaches HOLD_CYCLES-1, then reloads so that further strobes occur every REPEAT_CYCLES.
  - Is frozen outside HELD.
- Counter widths are `$clog2(max+1)` of the relevant parameter. Counters never wrap past their terminal value.
- Channels are fully independent. Simultaneous presses on several keys produce simultaneous strobes.
- Reset mid-operation:
  - All channels go to IDLE and all counters and outputs go to 0, with no `Released` strobe.
  - A key held through reset deassertion is re-debounced and produces a fresh `Pressed`.

## Timing
- All outputs are registered. Reset value of `Level`, `Pressed`, `Released` and `Repeat` is 0.
- Press latency: call edge 0 the first clock edge sampling `Keys_n[i]`=0.
  - The FSM enters DB_PRESS at edge 2.
  - `Pressed[i]` and `Level[i]` go high after edge 2+D. `Pressed` is high for exactly one cycle.
- Release latency is symmetric: `Released` is high for one cycle after edge 2+D, counted from the first sampled 1, and `Level` falls on the same edge.
- Any bounce shorter than D synchronised cycles produces no strobe and no `Level` change.
- For any channel, `Pressed` and `Released` are never high in the same cycle.
- `Repeat` is never coincident with `Pressed`.

## Structure
- Package `key_cond_pkg`: `key_state_t` enum (IDLE, DB_PRESS, HELD, DB_RELEASE) and a `cnt_width(max)` helper function.
- Sub-module `key_channel`: synchroniser, FSM, debounce counter and repeat timer for one key. It is instantiated N_KEYS times by a generate loop in `key_conditioner`.
- The top level only concatenates per-channel outputs.

## Test plan
Benches use `N_KEYS`=4, D=4, HOLD_CYCLES=10, REPEAT_CYCLES=3.
- **Clean press:** `Keys_n[0]` 1→0 and held.
  - `Pressed[0]`=1 for one cycle after edge 6, and `Level[0]`=1 from then on.
  - Release 0→1 gives `Released[0]` after edge 6 relative to the release.
- **Bounce reject:** `Keys_n[1]` low for 3 cycles, then high, repeated 5 times. All outputs on channel 1 stay 0.
- **Release bounce:** while held, `Keys_n[2]` high for 2 cycles then low again. `Level[2]` stays 1, and no `Released` or `Pressed` strobe occurs.
- **Auto-repeat** (`REPEAT_EN`=1): hold key 3 for 30 cycles after `Pressed`. `Repeat[3]` is strobed 10 cycles after entering HELD, then every 3 cycles. With `REPEAT_EN`=0, `Repeat` stays 0.
- **Simultaneous keys:** `Keys_n`=4'b0000 applied on one edge. `Pressed`=4'b1111 in the same cycle.
- **Reset mid-press:** drive `Reset`=0 for 2 cycles while key 0 is in HELD, keeping the key held.
  - All outputs go to 0 at the reset edge, with no `Released`.
  - After `Reset` returns to 1, `Pressed[0]` occurs again after 2+D cycles.
